// File: rtl/fp_acc.sv
// fp_acc: serial binary32 accumulator fed from fp_mul.
// Each accepted operand is added into acc over four states (align, add,
// normalise, round), so acc updates on the fourth enabled edge after an accept.
//
// state | meaning
// IDLE  | waiting for an operand; in_ready may be high
// ALIGN | unpack, swap by magnitude, shift the smaller significand, detect specials
// ADD   | add or subtract the aligned significands
// NORM  | renormalise on carry-out or leading zeros
// ROUND | round to nearest even, saturate, write acc
module fp_acc #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             areset,
  input  logic             en,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      d,
  output logic [31:0]      acc,
  output logic             busy,
  output logic [CNT_W-1:0] count
);

  localparam logic [31:0] QNAN = 32'h7FC00000;

  typedef enum logic [2:0] {IDLE, ALIGN, ADD, NORM, ROUND} state_t;

  state_t      state;
  logic [31:0] op_q;
  logic [27:0] big_sig, small_sig, sum_sig;   // [27] carry, [26] hidden, [2] G, [1] R, [0] sticky
  logic [9:0]  res_exp;                       // two's complement so underflow is visible
  logic        res_sign, eff_sub, spec, zero_res;
  logic [31:0] spec_val;

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    lzc27 = 5'd27;
    for (int i = 0; i < 27; i++)
      if (v[i]) lzc27 = 5'(26 - i);
  endfunction

  logic        a_sign, b_sign;
  logic [7:0]  a_exp, b_exp;
  logic [22:0] a_man, b_man;
  logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  assign {a_sign, a_exp, a_man} = acc;
  assign {b_sign, b_exp, b_man} = op_q;
  // Denormals have a zero exponent, so they fall into the zero class here.
  assign a_zero = (a_exp == 8'd0);
  assign b_zero = (b_exp == 8'd0);
  assign a_inf  = (a_exp == 8'hFF) && (a_man == 23'd0);
  assign b_inf  = (b_exp == 8'hFF) && (b_man == 23'd0);
  assign a_nan  = (a_exp == 8'hFF) && (a_man != 23'd0);
  assign b_nan  = (b_exp == 8'hFF) && (b_man != 23'd0);

  assign in_ready = areset & en & ~clear & (state == IDLE);
  assign busy     = (state != IDLE);

  logic        spec_c;
  logic [31:0] spec_val_c;

  // Operands whose result is fixed without running the datapath.
  always_comb begin
    spec_c     = 1'b1;
    spec_val_c = 32'd0;
    if (a_nan || b_nan)      spec_val_c = QNAN;
    else if (a_inf && b_inf) spec_val_c = (a_sign != b_sign) ? QNAN : acc;
    else if (a_inf)          spec_val_c = acc;
    else if (b_inf)          spec_val_c = op_q;
    else if (a_zero && b_zero) spec_val_c = {a_sign & b_sign, 31'd0};
    else if (a_zero)         spec_val_c = op_q;
    else if (b_zero)         spec_val_c = acc;
    else                     spec_c = 1'b0;
  end

  logic        swap, big_sign;
  logic [7:0]  big_exp, small_exp, exp_diff;
  logic [22:0] big_man, small_man;
  logic [27:0] small_full, aligned;

  // Order by magnitude and right-align the smaller significand with sticky.
  always_comb begin
    swap       = (op_q[30:0] > acc[30:0]);
    big_sign   = swap ? b_sign : a_sign;
    big_exp    = swap ? b_exp : a_exp;
    big_man    = swap ? b_man : a_man;
    small_exp  = swap ? a_exp : b_exp;
    small_man  = swap ? a_man : b_man;
    exp_diff   = big_exp - small_exp;
    small_full = {2'b01, small_man, 3'b000};
    if (exp_diff >= 8'd26)
      aligned = 28'd1;
    else
      aligned = (small_full >> exp_diff[4:0])
              | {27'd0, |(small_full & ~(28'hFFFFFFF << exp_diff[4:0]))};
  end

  logic [4:0]  lz;
  logic        round_up;
  logic [24:0] rnd_sig;
  logic [9:0]  rnd_exp;
  logic [22:0] rnd_man;
  logic [31:0] result;

  // Leading-zero count for NORM and round-to-nearest-even result for ROUND.
  always_comb begin
    lz       = lzc27(sum_sig[26:0]);
    round_up = sum_sig[2] & (sum_sig[1] | sum_sig[0] | sum_sig[3]);
    rnd_sig  = {1'b0, sum_sig[26:3]} + {24'd0, round_up};
    rnd_exp  = res_exp + {9'd0, rnd_sig[24]};
    rnd_man  = rnd_sig[24] ? 23'd0 : rnd_sig[22:0];
    if (spec)                                result = spec_val;
    else if (zero_res)                       result = 32'd0;
    else if (rnd_exp[9] || rnd_exp == 10'd0) result = {res_sign, 31'd0};
    else if (rnd_exp >= 10'd255)             result = {res_sign, 8'hFF, 23'd0};
    else                                     result = {res_sign, rnd_exp[7:0], rnd_man};
  end

  // Sequencer and datapath registers; everything holds while en is low.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      state     <= IDLE;
      acc       <= 32'd0;
      count     <= '0;
      op_q      <= 32'd0;
      big_sig   <= 28'd0;
      small_sig <= 28'd0;
      sum_sig   <= 28'd0;
      res_exp   <= 10'd0;
      res_sign  <= 1'b0;
      eff_sub   <= 1'b0;
      spec      <= 1'b0;
      spec_val  <= 32'd0;
      zero_res  <= 1'b0;
    end else if (en) begin
      if (clear) begin
        acc   <= 32'd0;
        count <= '0;
        state <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              op_q <= d;
              if (count != '1) count <= count + CNT_W'(1);
              state <= ALIGN;
            end
          end
          ALIGN: begin
            spec      <= spec_c;
            spec_val  <= spec_val_c;
            big_sig   <= {2'b01, big_man, 3'b000};
            small_sig <= aligned;
            eff_sub   <= a_sign ^ b_sign;
            res_sign  <= big_sign;
            res_exp   <= {2'b00, big_exp};
            state     <= ADD;
          end
          ADD: begin
            sum_sig <= eff_sub ? (big_sig - small_sig) : (big_sig + small_sig);
            state   <= NORM;
          end
          NORM: begin
            zero_res <= (sum_sig == 28'd0);
            if (sum_sig[27]) begin
              sum_sig <= {1'b0, sum_sig[27:2], sum_sig[1] | sum_sig[0]};
              res_exp <= res_exp + 10'd1;
            end else begin
              sum_sig <= sum_sig << lz;
              res_exp <= res_exp - {5'd0, lz};
            end
            state <= ROUND;
          end
          ROUND: begin
            acc   <= result;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/fp_acc.md
# fp_acc

Single-precision floating-point accumulator that sits directly downstream of `fp_mul`: it consumes each product `q` and adds it into a running IEEE-754 binary32 sum. The add is performed by a multi-cycle serial datapath (align, add, normalise, round), so the block never needs a second pipelined adder. A valid/ready handshake lets the surrounding control hold `fp_mul` results until the accumulator can take them.

## Interface
- `CNT_W`, 16, width of the accepted-operand counter.

- `clk` in 1: system clock; all state changes on its rising edge.
- `areset` in 1: asynchronous, active-low reset.
- `en` in 1: clock enable, same meaning as on `fp_mul`. When low, all state is frozen and `in_ready` is forced to 0.
- `clear` in 1: synchronous clear of the sum and the counter.
- `in_valid` in 1: `d` holds a new operand.
- `in_ready` out 1: the block can accept an operand this cycle.
- `d` in 32: binary32 operand, normally an `fp_mul` `q`.
- `acc` out 32: current binary32 sum, registered.
- `busy` out 1: an add is in progress.
- `count` out CNT_W: number of operands accepted since the last reset or clear. Saturates at all-ones.

## Operation
- Reset (`areset`=0) values: `acc`=0x00000000, `count`=0, `busy`=0, FSM state=IDLE, internal registers cleared. `in_ready` is 0 while reset is asserted.
- FSM states: IDLE → ALIGN → ADD → NORM → ROUND → IDLE. Each state lasts one enabled cycle.
- IDLE:
  - `in_ready` = `en` & ~`clear`.
  - An accept is `in_valid` & `in_ready`. On an accept, latch `d`, increment `count` (saturating) and go to ALIGN.
- ALIGN:
  - Unpack `acc` and the latched operand, restoring the hidden bit.
  - Swap the operands so the larger magnitude is first.
  - Right-shift the smaller significand by the exponent difference. Keep guard and round bits; OR all bits shifted out into sticky.
  - An exponent difference ≥ 26 leaves only sticky.
- ADD: add or subtract the significands according to the effective sign, in a 28-bit datapath. The result sign is the sign of the larger operand.
- NORM:
  - On carry-out, shift right by 1 and increment the exponent; the shifted-out bit is ORed into sticky.
  - Otherwise shift left by the leading-zero count and decrement the exponent by the same amount.
- ROUND:
  - Round to nearest, ties to even.
  - A mantissa carry from rounding increments the exponent.
  - Write `acc` and return to IDLE.
- Special cases, resolved in ALIGN; the result is still written at ROUND so latency stays fixed:
  - Denormal inputs, in `d` or in `acc`, are treated as zero of the same sign.
  - Any NaN operand → `acc`=0x7FC00000.
  - +inf + −inf → 0x7FC00000.
  - inf + finite → that inf.
  - Exponent overflow after rounding → ±inf (0x7F800000 | sign).
  - Result exponent ≤ 0 → ±0, sign kept.
  - Exact cancellation → +0 (0x00000000).
  - (+0) + (−0) → +0; (−0) + (−0) → −0.
- `clear`, sampled only when `en`=1:
  - In IDLE it sets `acc`=0 and `count`=0. If `in_valid` is also high, no accept happens.
  - In any other state it aborts the add: `acc`=0, `count`=0, go to IDLE. The in-flight operand is discarded.
- `busy` = 1 in ALIGN, ADD, NORM and ROUND.

## Timing
- Accept at edge N (IDLE). ALIGN, ADD, NORM and ROUND occupy edges N+1 to N+4. `acc` shows the new sum after edge N+4.
- `in_ready` is high again in the cycle following edge N+4, so the sustained throughput is one operand per 5 enabled cycles.
- `en`=0 stretches every state by the number of disabled cycles. No state or output changes while `en`=0.
- `count` updates at the accept edge. `acc` updates only at the ROUND edge or on a clear.
- An `areset` assertion mid-operation immediately forces the reset values. The in-flight operand is lost.

## Test plan
- Reset, then accept 0x3F800000 (1.0) followed by 0x40000000 (2.0) → `acc`=0x3F800000 and then 0x40400000 (3.0). Each is visible 4 cycles after its accept; `count`=2.
- Ties to even:
  - From `acc`=0x3F800000, add 0x33800000 (2^-24) → `acc` stays 0x3F800000.
  - From 0x3F800001, add 0x33800000 → 0x3F800002.
- From `acc`=0x3F800000, add 0xBF800000 → 0x00000000. From 0x7F7FFFFF, add 0x7F7FFFFF → 0x7F800000.
- Specials:
  - Accept 0x7F800000 then 0xFF800000 → 0x7FC00000.
  - A further accept of 0x3F800000 leaves 0x7FC00000.
  - Accepting 0x00000001 (denormal) into 1.0 leaves 0x3F800000.
- Clear and enable:
  - Assert `clear` in the ADD state → `acc`=0, `count`=0, `busy`=0 on the next edge.
  - Hold `en`=0 for 3 cycles during NORM → the result arrives 3 cycles late and is otherwise unchanged.
- Drive `areset` low during ROUND → `acc`=0, `in_ready`=0 immediately. After release, `in_ready`=1 on the first enabled cycle.
